wb_pipe_reg: RTL

- Parametrised MEM->WB pipeline register; successor to the fixed single-port MEM/WB latch.
- Carries NCH general register write channels, the HI/LO write and the LLbit update.
- Adds a valid bit, synchronous flush, optional R0 write suppression and a saturating retired-instruction counter.
- Sits between the memory stage and the register file / HI-LO / LLbit write logic; driven by the core stall controller.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/wb_pipe_reg_sat_counter.sv | 34 +++
 rtl/wb_pipe_reg.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: stall-action encoding, default widths and the
// value pipeline state takes while reset is asserted.
package cpu_pkg;

   localparam int DW_DEF = 32;
   localparam int AW_DEF = 5;

   localparam logic RST_VAL = 1'b0;

   typedef enum logic [1:0] {
      ACT_ADVANCE = 2'd0,
      ACT_BUBBLE  = 2'd1,
      ACT_HOLD    = 2'd2
   } stall_act_e;

   // A stalled stage whose successor keeps moving must emit a bubble;
   // flush outranks everything, including a full hold.
   function automatic stall_act_e stall_action(input logic flush,
                                               input logic s,
                                               input logic n);
      stall_act_e act;
      if (flush)
         act = ACT_BUBBLE;
      else if (s && !n)
         act = ACT_BUBBLE;
      else if (s)
         act = ACT_HOLD;
      else
         act = ACT_ADVANCE;
      return act;
   endfunction

endpackage

// File: rtl/wb_pipe_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (&v)
         r = v;
      else
         r = v + 1'b1;
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_p1 <= '0;
      else if (clr)
         cnt_p1 <= '0;
      else if (inc)
         cnt_p1 <= sat_inc(cnt_p1);
   end

   assign cnt = cnt_p1;

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register: NCH register write channels, HI/LO and LLbit,
// with valid, flush, optional R0 write suppression and a retired counter.
module wb_pipe_reg
   import cpu_pkg::*;
#(
   parameter int DW            = DW_DEF,
   parameter int AW            = AW_DEF,
   parameter int NCH           = 1,
   parameter int STALL_W       = 6,
   parameter int STAGE         = 4,
   parameter int ZERO_SUPPRESS = 1,
   parameter int CNT_W         = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [STALL_W-1:0]  stall,
   input  logic                flush,
   input  logic                in_valid,
   input  logic [NCH-1:0]      in_we,
   input  logic [NCH*AW-1:0]   in_waddr,
   input  logic [NCH*DW-1:0]   in_wdata,
   input  logic                in_whilo,
   input  logic [DW-1:0]       in_hi,
   input  logic [DW-1:0]       in_lo,
   input  logic                in_llbit_we,
   input  logic                in_llbit_value,
   input  logic                cnt_clr,
   output logic                out_valid,
   output logic [NCH-1:0]      out_we,
   output logic [NCH*AW-1:0]   out_waddr,
   output logic [NCH*DW-1:0]   out_wdata,
   output logic                out_whilo,
   output logic [DW-1:0]       out_hi,
   output logic [DW-1:0]       out_lo,
   output logic                out_llbit_we,
   output logic                out_llbit_value,
   output logic [CNT_W-1:0]    retired_cnt
);

   logic             n_bit;
   logic             unused_stall;
   stall_act_e       act;
   logic [NCH-1:0]   we_adv;

   logic              vld_p1;
   logic [NCH-1:0]    we_p1;
   logic [NCH*AW-1:0] waddr_p1;
   logic [NCH*DW-1:0] wdata_p1;
   logic              whilo_p1;
   logic [DW-1:0]     hi_p1;
   logic [DW-1:0]     lo_p1;
   logic              llbit_we_p1;
   logic              llbit_value_p1;

   // The last stage in the stall vector has no successor to wait on.
   if (STAGE < STALL_W - 1) begin : g_next
      assign n_bit = stall[STAGE+1];
   end else begin : g_last
      assign n_bit = 1'b0;
   end

   assign unused_stall = ^stall;
   assign act          = stall_action(flush, stall[STAGE], n_bit);

   always_comb begin
      we_adv = in_we;
      for (int k = 0; k < NCH; k++) begin
         if ((ZERO_SUPPRESS != 0) && (in_waddr[k*AW +: AW] == '0))
            we_adv[k] = 1'b0;
      end
   end

   // MEM -> WB boundary
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1         <= RST_VAL;
         we_p1          <= '0;
         waddr_p1       <= '0;
         wdata_p1       <= '0;
         whilo_p1       <= RST_VAL;
         hi_p1          <= '0;
         lo_p1          <= '0;
         llbit_we_p1    <= RST_VAL;
         llbit_value_p1 <= RST_VAL;
      end else begin
         case (act)
            ACT_ADVANCE: begin
               vld_p1         <= in_valid;
               we_p1          <= we_adv;
               waddr_p1       <= in_waddr;
               wdata_p1       <= in_wdata;
               whilo_p1       <= in_whilo;
               hi_p1          <= in_hi;
               lo_p1          <= in_lo;
               llbit_we_p1    <= in_llbit_we;
               llbit_value_p1 <= in_llbit_value;
            end
            ACT_BUBBLE: begin
               vld_p1         <= 1'b0;
               we_p1          <= '0;
               waddr_p1       <= '0;
               wdata_p1       <= '0;
               whilo_p1       <= 1'b0;
               hi_p1          <= '0;
               lo_p1          <= '0;
               llbit_we_p1    <= 1'b0;
               llbit_value_p1 <= 1'b0;
            end
            default: begin
               vld_p1         <= vld_p1;
               we_p1          <= we_p1;
               waddr_p1       <= waddr_p1;
               wdata_p1       <= wdata_p1;
               whilo_p1       <= whilo_p1;
               hi_p1          <= hi_p1;
               lo_p1          <= lo_p1;
               llbit_we_p1    <= llbit_we_p1;
               llbit_value_p1 <= llbit_value_p1;
            end
         endcase
      end
   end

   // Flush already forces a bubble action, so it never counts here.
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_retired (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     ((act == ACT_ADVANCE) && in_valid),
      .clr     (cnt_clr),
      .cnt     (retired_cnt)
   );

   assign out_valid       = vld_p1;
   assign out_we          = we_p1;
   assign out_waddr       = waddr_p1;
   assign out_wdata       = wdata_p1;
   assign out_whilo       = whilo_p1;
   assign out_hi          = hi_p1;
   assign out_lo          = lo_p1;
   assign out_llbit_we    = llbit_we_p1;
   assign out_llbit_value = llbit_value_p1;

endmodule
